// File: rtl/branch_seq_ctrl.sv
// Conditional-branch sequencer: walks the datapath through EVAL, PC, ADD and LOAD
// with registered strobes, and keeps a saturating count of taken branches.
module branch_seq_ctrl #(
    parameter logic [4:0] OPCODE_BR = 5'b10010,
    parameter int         CNT_W     = 16
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [31:0]      ir,
    input  logic             hold,
    input  logic             con_q,
    output logic [1:0]       cond_sel,
    output logic [3:0]       ra_sel,
    output logic             r_out,
    output logic             con_in,
    output logic             pc_out,
    output logic             y_in,
    output logic             c_out,
    output logic             alu_add,
    output logic             z_in,
    output logic             zlo_out,
    output logic             pc_in,
    output logic             busy,
    output logic             done,
    output logic             taken,
    output logic             err,
    output logic [CNT_W-1:0] taken_cnt
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        EVAL = 3'd1,
        PC   = 3'd2,
        ADD  = 3'd3,
        LOAD = 3'd4
    } state_t;

    typedef struct packed {
        logic r_out;
        logic con_in;
        logic pc_out;
        logic y_in;
        logic c_out;
        logic alu_add;
        logic z_in;
        logic zlo_out;
        logic pc_in;
        logic done;
    } strobes_t;

    state_t            state_q, state_d;
    strobes_t          str_q, str_d;
    logic [1:0]        cond_q, cond_d;
    logic [3:0]        ra_q, ra_d;
    logic [18:0]       cimm_q, cimm_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic              taken_q, taken_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Strobes are decoded from the state being entered, so each one is a flop
    // output that is valid for the whole cycle of its phase.
    always_comb begin
        state_d = state_q;
        str_d   = str_q;
        cond_d  = cond_q;
        ra_d    = ra_q;
        cimm_d  = cimm_q;
        busy_d  = busy_q;
        err_d   = err_q;
        taken_d = taken_q;
        cnt_d   = cnt_q;

        if (!(hold && state_q != IDLE)) begin
            str_d = '0;
            err_d = 1'b0;

            case (state_q)
                IDLE: begin
                    if (start && !hold) begin
                        if (ir[31:27] == OPCODE_BR) begin
                            cond_d  = ir[20:19];
                            ra_d    = ir[26:23];
                            cimm_d  = ir[18:0];
                            state_d = EVAL;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                EVAL:    state_d = PC;
                PC:      state_d = ADD;
                ADD:     state_d = LOAD;
                LOAD:    state_d = IDLE;
                default: state_d = IDLE;
            endcase

            busy_d = (state_d != IDLE);

            case (state_d)
                EVAL: begin
                    str_d.r_out  = 1'b1;
                    str_d.con_in = 1'b1;
                end
                PC: begin
                    str_d.pc_out = 1'b1;
                    str_d.y_in   = 1'b1;
                end
                ADD: begin
                    str_d.c_out   = 1'b1;
                    str_d.alu_add = 1'b1;
                    str_d.z_in    = 1'b1;
                end
                LOAD: begin
                    // CON was latched at the end of EVAL, so it is settled here.
                    str_d.zlo_out = 1'b1;
                    str_d.pc_in   = con_q;
                    str_d.done    = 1'b1;
                    taken_d       = con_q;
                    if (con_q && (cnt_q != {CNT_W{1'b1}})) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= IDLE;
            str_q   <= '0;
            cond_q  <= '0;
            ra_q    <= '0;
            cimm_q  <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            taken_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            str_q   <= str_d;
            cond_q  <= cond_d;
            ra_q    <= ra_d;
            cimm_q  <= cimm_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            taken_q <= taken_d;
            cnt_q   <= cnt_d;
        end
    end

    // The C field is kept for the datapath's sign extender; ir[22:21] is reserved.
    logic unused_bits;
    assign unused_bits = ^{ir[22:21], cimm_q};

    assign cond_sel  = cond_q;
    assign ra_sel    = ra_q;
    assign r_out     = str_q.r_out;
    assign con_in    = str_q.con_in;
    assign pc_out    = str_q.pc_out;
    assign y_in      = str_q.y_in;
    assign c_out     = str_q.c_out;
    assign alu_add   = str_q.alu_add;
    assign z_in      = str_q.z_in;
    assign zlo_out   = str_q.zlo_out;
    assign pc_in     = str_q.pc_in;
    assign done      = str_q.done;
    assign busy      = busy_q;
    assign err       = err_q;
    assign taken     = taken_q;
    assign taken_cnt = cnt_q;

endmodule
